pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the RV32I core.

---
 rtl/pc_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer for the RV32I core.
// Fetches one instruction per req/ack handshake and holds it while the datapath
// executes it. On commit it moves to the next PC, which comes from the ALU branch
// flag, the ALU result (jalr) or the decoded immediate. If the next PC is
// misaligned, the unit traps and stays trapped until reset.
`timescale 1ns/1ps

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_npc_op,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_alu_c,
    input  logic        i_alu_f,
    input  logic        i_commit,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic        o_misalign
);

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [1:0]  OP_SEQ  = 2'b00;
    localparam logic [1:0]  OP_BR   = 2'b01;
    localparam logic [1:0]  OP_JAL  = 2'b10;
    localparam logic [1:0]  OP_JALR = 2'b11;

    typedef enum logic [1:0] {
        ST_RST   = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_TRAP  = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic        r_imem_req;
    logic        r_misalign;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_inst_nxt;
    logic        w_inst_valid_nxt;
    logic        w_imem_req_nxt;
    logic        w_misalign_nxt;

    logic [31:0] w_pc4;
    logic [31:0] w_pc_imm;
    logic [31:0] w_npc;
    logic        w_npc_bad;

    assign w_pc4    = r_pc + 32'd4;
    assign w_pc_imm = r_pc + i_imm;

    // Next-PC selection; alu_f only matters for branches.
    always_comb begin
        w_npc = w_pc4;
        case (i_npc_op)
            OP_SEQ:  w_npc = w_pc4;
            OP_BR:   w_npc = i_alu_f ? w_pc_imm : w_pc4;
            OP_JAL:  w_npc = w_pc_imm;
            OP_JALR: w_npc = {i_alu_c[31:1], 1'b0};
            default: w_npc = w_pc4;
        endcase
    end

    // Bit 0 is always clear for jalr, so bit 1 is the usual culprit.
    assign w_npc_bad = ALIGN_CHECK && (w_npc[1:0] != 2'b00);

    // Sequencer next state and next register values; everything holds by default.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_nxt       = r_inst;
        w_inst_valid_nxt = r_inst_valid;
        w_imem_req_nxt   = r_imem_req;
        w_misalign_nxt   = r_misalign;
        case (r_state)
            ST_RST: begin
                w_state_nxt    = ST_FETCH;
                w_imem_req_nxt = 1'b1;
            end
            ST_FETCH: begin
                if (i_imem_ack) begin
                    w_inst_nxt       = i_imem_rdata;
                    w_inst_valid_nxt = 1'b1;
                    w_imem_req_nxt   = 1'b0;
                    w_state_nxt      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (i_commit) begin
                    w_inst_valid_nxt = 1'b0;
                    if (w_npc_bad) begin
                        w_misalign_nxt = 1'b1;
                        w_state_nxt    = ST_TRAP;
                    end else begin
                        w_pc_nxt       = w_npc;
                        w_imem_req_nxt = 1'b1;
                        w_state_nxt    = ST_FETCH;
                    end
                end
            end
            ST_TRAP: begin
                w_state_nxt = ST_TRAP;
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    // State and output registers; reset drops any outstanding fetch.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_RST;
            r_pc         <= RESET_PC;
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
            r_imem_req   <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_imem_req   <= w_imem_req_nxt;
            r_misalign   <= w_misalign_nxt;
        end
    end

    assign o_imem_req   = r_imem_req;
    assign o_imem_addr  = r_pc;
    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_pc         = r_pc;
    assign o_pc4        = w_pc4;
    assign o_misalign   = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized bench for pc_fetch_unit.
// Stimulus pushes each accepted fetch into a queue; a negedge monitor pops it when
// inst_valid rises. Next-PC expectations come from a small arithmetic model.
`timescale 1ns/1ps

module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic [31:0] imm = 32'h0;
    logic [31:0] alu_c = 32'h0;
    logic        alu_f = 1'b0;
    logic        commit = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;

    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        misalign;

    logic        na_req;
    logic [31:0] na_addr;
    logic [31:0] na_inst;
    logic        na_valid;
    logic [31:0] na_pc;
    logic [31:0] na_pc4;
    logic        na_misalign;

    pc_fetch_unit #(.RESET_PC(RST_PC), .ALIGN_CHECK(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_npc_op(npc_op), .i_imm(imm),
        .i_alu_c(alu_c), .i_alu_f(alu_f), .i_commit(commit),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack),
        .i_imem_rdata(rdata), .o_inst(inst), .o_inst_valid(valid),
        .o_pc(pc), .o_pc4(pc4), .o_misalign(misalign)
    );

    // Same inputs, no alignment check: only inspected right after the jal-by-6 commit.
    pc_fetch_unit #(.RESET_PC(RST_PC), .ALIGN_CHECK(1'b0)) dut_na (
        .i_clk(clk), .i_rst_n(rst_n), .i_npc_op(npc_op), .i_imm(imm),
        .i_alu_c(alu_c), .i_alu_f(alu_f), .i_commit(commit),
        .o_imem_req(na_req), .o_imem_addr(na_addr), .i_imem_ack(ack),
        .i_imem_rdata(rdata), .o_inst(na_inst), .o_inst_valid(na_valid),
        .o_pc(na_pc), .o_pc4(na_pc4), .o_misalign(na_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_t;

    fetch_t      exp_q[$];
    fetch_t      mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_pc = RST_PC;
    logic [31:0] last_inst = 32'h13;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising inst_valid must match the oldest accepted fetch.
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL mon_unexpected_valid: got pc %h expected no instruction", pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_pc", pc, mon_e.addr);
                chk("mon_inst", inst, mon_e.inst);
                chk("mon_pc4", pc4, mon_e.addr + 32'd4);
            end
        end
        prev_valid <= valid;
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        commit = 1'b0;
        ack    = 1'b0;
        tick();
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 32'h0000_0013);
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_req", req, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        rst_n     = 1'b1;
        model_pc  = RST_PC;
        last_inst = 32'h0000_0013;
        tick();
        chk1("req_after_rst", req, 1'b1);
        chk("addr_after_rst", addr, RST_PC);
    endtask

    // Called with the DUT in FETCH: wait dly cycles (optionally with ignored commits), then ack.
    task automatic fetch(input int dly, input bit spur, input logic [31:0] data);
        for (int i = 0; i < dly; i++) begin
            ack    = 1'b0;
            commit = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            npc_op = 2'($urandom_range(0, 3));
            imm    = $urandom;
            rdata  = $urandom;
            tick();
            chk1("fetch_req_hold", req, 1'b1);
            chk("fetch_addr_stable", addr, model_pc);
            chk1("fetch_valid_low", valid, 1'b0);
        end
        commit = 1'b0;
        ack    = 1'b1;
        rdata  = data;
        exp_q.push_back('{model_pc, data});
        last_inst = data;
        tick();
        ack = 1'b0;
        chk1("valid_after_ack", valid, 1'b1);
        chk1("req_after_ack", req, 1'b0);
    endtask

    // Called with the DUT in EXEC: wait dly cycles (with ignored acks), then commit.
    task automatic exec(input int dly, input logic [1:0] op, input logic [31:0] im,
                        input logic [31:0] ac, input logic f, output bit trapped);
        logic [31:0] npc;
        for (int i = 0; i < dly; i++) begin
            commit = 1'b0;
            ack    = 1'($urandom_range(0, 1));
            rdata  = $urandom;
            tick();
            chk1("exec_valid_hold", valid, 1'b1);
            chk("exec_pc4", pc4, model_pc + 32'd4);
            chk1("exec_req_low", req, 1'b0);
        end
        ack    = 1'b0;
        npc_op = op;
        imm    = im;
        alu_c  = ac;
        alu_f  = f;
        commit = 1'b1;
        chk("inst_held", inst, last_inst);
        tick();
        commit = 1'b0;
        case (op)
            2'd0:    npc = model_pc + 32'd4;
            2'd1:    npc = f ? model_pc + im : model_pc + 32'd4;
            2'd2:    npc = model_pc + im;
            default: npc = ac & 32'hFFFF_FFFE;
        endcase
        trapped = (npc % 4) != 0;
        if (trapped) begin
            chk1("trap_misalign", misalign, 1'b1);
            chk1("trap_valid", valid, 1'b0);
            chk1("trap_req", req, 1'b0);
            chk("trap_pc", pc, model_pc);
            for (int i = 0; i < 3; i++) begin
                commit = 1'($urandom_range(0, 1));
                ack    = 1'($urandom_range(0, 1));
                rdata  = $urandom;
                tick();
                chk1("trap_hold_misalign", misalign, 1'b1);
                chk1("trap_hold_req", req, 1'b0);
                chk("trap_hold_pc", pc, model_pc);
                chk("trap_hold_inst", inst, last_inst);
                chk1("trap_hold_valid", valid, 1'b0);
            end
            commit = 1'b0;
            ack    = 1'b0;
        end else begin
            chk("commit_pc", pc, npc);
            chk("commit_addr", addr, npc);
            chk1("commit_req", req, 1'b1);
            chk1("commit_valid", valid, 1'b0);
            chk1("commit_misalign", misalign, 1'b0);
            model_pc = npc;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          t;
        logic [1:0]  op;
        logic [31:0] im;
        logic [31:0] ac;
        bit          mis;

        do_reset();
        // Zero-wait fetch then sequential commit.
        fetch(0, 1'b0, 32'h0050_0093);
        exec(1, 2'd0, 32'h0, 32'h0, 1'b0, t);
        // Reach 0x200, then branch by -8 taken and not taken.
        fetch(0, 1'b0, $urandom);
        exec(0, 2'd2, 32'h0000_00FC, 32'h0, 1'b0, t);
        fetch(0, 1'b0, $urandom);
        exec(0, 2'd1, 32'hFFFF_FFF8, 32'h0, 1'b1, t);
        fetch(0, 1'b0, $urandom);
        exec(0, 2'd2, 32'h0000_0008, 32'h0, 1'b0, t);
        fetch(0, 1'b0, $urandom);
        exec(0, 2'd1, 32'hFFFF_FFF8, 32'h0, 1'b0, t);
        // jalr clears bit 0.
        fetch(0, 1'b0, $urandom);
        exec(2, 2'd3, 32'h0, 32'h0000_1235, 1'b1, t);
        // Delayed ack with spurious commits, then wrap at the top of the address space.
        fetch(3, 1'b1, $urandom);
        exec(0, 2'd3, 32'h0, 32'hFFFF_FFFD, 1'b0, t);
        fetch(0, 1'b0, $urandom);
        exec(1, 2'd0, 32'h0, 32'h0, 1'b0, t);
        // alu_f with a non-branch op is ignored.
        fetch(1, 1'b0, $urandom);
        exec(0, 2'd0, 32'h0000_0003, 32'h0, 1'b1, t);
        // Reset in the middle of a pending fetch.
        ack = 1'b0;
        tick();
        chk1("midfetch_req", req, 1'b1);
        do_reset();
        // jal to 0x300, then jal by 6 traps; the unchecked instance goes to 0x306.
        fetch(0, 1'b0, $urandom);
        exec(0, 2'd2, 32'h0000_0200, 32'h0, 1'b0, t);
        fetch(0, 1'b0, $urandom);
        chk("jal_pc_before", pc, 32'h0000_0300);
        exec(0, 2'd2, 32'h0000_0006, 32'h0, 1'b0, t);
        chk1("trap_expected", t, 1'b1);
        do_reset();
        // Re-run the jal-by-6 case and inspect the unchecked instance right after commit.
        fetch(0, 1'b0, $urandom);
        exec(0, 2'd2, 32'h0000_0200, 32'h0, 1'b0, t);
        fetch(0, 1'b0, $urandom);
        ack    = 1'b0;
        npc_op = 2'd2;
        imm    = 32'h0000_0006;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("noalign_pc", na_pc, 32'h0000_0306);
        chk1("noalign_misalign", na_misalign, 1'b0);
        chk1("noalign_req", na_req, 1'b1);
        chk1("align_trap_misalign", misalign, 1'b1);
        chk("align_trap_pc", pc, 32'h0000_0300);
        do_reset();

        // Randomized transactions.
        for (int n = 0; n < 150; n++) begin
            fetch($urandom_range(0, 3), 1'b1, $urandom);
            op  = 2'($urandom_range(0, 3));
            mis = ($urandom_range(0, 9) == 0);
            im  = $urandom & 32'h0000_1FFC;
            if ($urandom_range(0, 1) == 1) im = -im;
            if (mis) im = im | 32'd2;
            ac  = $urandom & 32'hFFFF_FFFD;
            if (mis) ac = ac | 32'd2;
            exec($urandom_range(0, 3), op, im, ac, 1'($urandom_range(0, 1)), t);
            if (t) do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
